// File: rtl/input_conditioner.sv
// Switch/button front end: 2-flop synchronizer per channel feeding a debounce FSM
// that emits a clean level plus one-clock rise/fall strobes.

module input_conditioner_lane #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sync,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_level, w_level_nxt;
  logic             r_rise, w_rise_nxt;
  logic             r_fall, w_fall_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Counter is cleared on every state change; equality compare means no saturation logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    unique case (r_state)
      STABLE_LO: begin
        if (i_sync) begin
          w_state_nxt = PEND_HI;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt = '0;
        end
      end
      PEND_HI: begin
        if (!i_sync) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_rise_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!i_sync) begin
          w_state_nxt = PEND_LO;
          w_cnt_nxt   = CNT_ONE;
        end else begin
          w_cnt_nxt = '0;
        end
      end
      PEND_LO: begin
        if (i_sync) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
          w_fall_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

module input_conditioner #(
  parameter int NUM_IN          = 3,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IN-1:0] raw_in,
  output logic [NUM_IN-1:0] level_out,
  output logic [NUM_IN-1:0] rise_pulse,
  output logic [NUM_IN-1:0] fall_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [NUM_IN-1:0] r_s1, r_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= raw_in;
      r_s2 <= r_s1;
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : g_lane
    input_conditioner_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_sync (r_s2[g]),
      .o_level(level_out[g]),
      .o_rise (rise_pulse[g]),
      .o_fall (fall_pulse[g])
    );
  end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Front-end stage for the board's slide switches and push button.
- Feeds the display/calculator top level with clean `direction`/`mode` levels and a single-cycle `btn` pulse.
- Per channel: 2-flop synchronizer, then a debounce FSM with a stability counter.
- Outputs a debounced level plus one-cycle rise/fall strobes, so downstream FSMs advance exactly once per physical press regardless of bounce.

Parameters:
- NUM_IN, 3: number of independent input channels (bit 0 = btn, 1 = direction, 2 = mode by board convention).
- DEBOUNCE_CYCLES, 1000000: consecutive clocks the synchronized input must hold a new value before acceptance (10 ms at 100 MHz). Legal range is 1 or more.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): counter width, derived, not overridden.

Ports:
- clk  input  1  system clock, all flops on rising edge.
- rst  input  1  asynchronous, active-low reset.
- raw_in  input  NUM_IN  unsynchronized switch/button pins.
- level_out  output  NUM_IN  debounced level per channel.
- rise_pulse  output  NUM_IN  one-clock strobe when level_out goes 0->1.
- fall_pulse  output  NUM_IN  one-clock strobe when level_out goes 1->0.

Behaviour:
- Reset (rst=0, async assert, sync release by board convention):
  - All sync flops, counters, level_out, rise_pulse, fall_pulse = 0.
  - Every channel FSM = STABLE_LO.
- Synchronizer:
  - s1 <= raw_in; s2 <= s1.
  - Only s2 feeds the FSM; raw_in never reaches logic directly.
- Per-channel FSM, 4 states, with cnt of CNT_W bits:
  - STABLE_LO: if s2=1 then go to PEND_HI and set cnt=1; else hold, cnt=0.
  - PEND_HI:
    - if s2=0 then go to STABLE_LO and set cnt=0 (glitch rejected, no strobe);
    - else if cnt=DEBOUNCE_CYCLES then go to STABLE_HI, level_out<=1, rise_pulse<=1 for that one cycle;
    - else cnt<=cnt+1.
  - STABLE_HI: if s2=0 then go to PEND_LO and set cnt=1; else hold.
  - PEND_LO: mirror of PEND_HI. Acceptance sets level_out<=0 and fall_pulse<=1 for one cycle. s2=1 during the count returns to STABLE_HI with no strobe.
- Latency:
  - Edge 1 is the first edge that samples the new raw value, held stable thereafter.
  - level_out and the strobe change after edge DEBOUNCE_CYCLES+3.
  - The strobe deasserts after the following edge.
- Strobes:
  - Registered, exactly one clock wide, never both high on one channel in the same cycle.
  - At most one strobe per accepted transition.
- Counter:
  - Saturation is never reached; cnt is compared for equality and reset on every state change.
  - With DEBOUNCE_CYCLES=1, acceptance occurs on the first PEND cycle.
- Channels are fully independent.
  - Simultaneous transitions on several channels produce simultaneous strobes on each.
- Bounce:
  - Any reversal of s2 inside a PEND state restarts from the stable state.
  - Continuous chatter therefore never changes level_out.
- Reset mid-operation:
  - Asserting rst in any state (including mid-PEND or during a strobe) returns all outputs to 0 immediately, without waiting for a clock.
  - After release, an input that is already high is re-debounced from STABLE_LO and produces a rise_pulse after the full latency.
- Output wiring: downstream logic uses rise_pulse[0] as btn, level_out[1] as direction, level_out[2] as mode.

Test Plan:
- Reset: rst=0 with raw_in=3'b111, then release. All outputs must be 0 during reset. level_out becomes 3'b111 and rise_pulse=3'b111 for one cycle after edge DEBOUNCE_CYCLES+3 post-release (check with DEBOUNCE_CYCLES=4: after edge 7).
- Clean press (DEBOUNCE_CYCLES=4): raise raw_in[0] and hold 20 cycles, then drop and hold 20 cycles.
  - rise_pulse[0] high exactly one cycle, after edge 7.
  - fall_pulse[0] high exactly one cycle, 7 edges after the drop.
  - level_out[0] tracks both.
- Bounce rejection (DEBOUNCE_CYCLES=4): toggle raw_in[0] as 1,0,1,1,0,1 for one cycle each, then hold 1.
  - No strobe during the chatter.
  - Exactly one rise_pulse[0], 7 edges after the last 0->1.
- Glitch: in STABLE_HI, a single-cycle low on raw_in[1] must produce no fall_pulse and leave level_out[1]=1.
- Independence: raise raw_in[0] and raw_in[2] on the same cycle, with raw_in[1] static. rise_pulse must be 3'b101 for exactly one shared cycle.
- Mid-debounce reset: assert rst two cycles into PEND_HI.
  - Outputs 0 asynchronously (checked before the next edge).
  - After release with raw held high, a single rise_pulse arrives after the full DEBOUNCE_CYCLES+3 edges.
